weight_buffer_ctrl: RTL
=======================

# weight_buffer_ctrl

Parametrised weight staging controller between the weight loader and the convolution cores. Holds the active kernel set driving the cores plus a shadow set prefetched in the background, so that a swap at channel/core end costs one cycle instead of a full reload. Sequences a programmed number of weight sets per run, raises a stall when a swap is requested before the prefetch lands, and flags protocol errors. Supersedes the fixed four-core, single-register weight latch control.

## Interface
- WEIGHT_WIDTH, 8, bits per weight element
- KERNEL_SIZE, 9, elements per kernel (3x3)
- NUM_CORES, 4, kernels presented in parallel, one per core
- SET_CNT_W, 8, width of weight-set counter
- Derived: BUS_W = NUM_CORES*KERNEL_SIZE*WEIGHT_WIDTH; core c occupies bits [(c+1)*KERNEL_SIZE*WEIGHT_WIDTH-1 : c*KERNEL_SIZE*WEIGHT_WIDTH]

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- init  in  1  run-start pulse; honoured only in IDLE
- num_sets  in  SET_CNT_W  weight sets in this run; sampled on accepted init
- load_done  in  1  loader pulse; weight_in valid in the same cycle
- weight_in  in  BUS_W  weights from loader
- channel_end  in  1  pipeline channel boundary
- core_end  in  1  pipeline core boundary; swap_req = channel_end & core_end
- load_start  out  1  one-cycle request to loader for next set
- weight_out  out  BUS_W  active weights to cores (registered)
- buffer_ready  out  1  weight_out holds a valid set for the run
- stall  out  1  swap requested, shadow empty; pipeline must hold
- done  out  1  one-cycle pulse: final set consumed
- err  out  1  sticky: load_done in IDLE/READY/LAST; cleared by accepted init

## Operation
- Registers: weight_out, shadow (BUS_W), issued count, pending_swap; FSM states IDLE, FILL, PREFETCH, READY, LAST.
- Reset (asynchronous): state IDLE; all outputs, shadow, counters, pending_swap = 0.
- IDLE: init with num_sets != 0 -> load_start=1, issued=1, err=0 -> FILL. init with num_sets == 0 is ignored (stays IDLE, err unchanged).
- FILL: load_done -> weight_out <= weight_in, buffer_ready=1; if issued < num_sets -> load_start=1, issued+1 -> PREFETCH; else -> LAST. swap_req ignored (buffer_ready still 0).
- PREFETCH, load_done without pending swap -> shadow <= weight_in -> READY.
- PREFETCH, swap_req with no load_done -> pending_swap=1, stall=1 (held).
- PREFETCH, load_done with pending_swap or simultaneous swap_req -> bypass: weight_out <= weight_in, stall=0, pending_swap=0; if issued < num_sets -> load_start=1, issued+1, stay PREFETCH; else -> LAST.
- READY: swap_req -> weight_out <= shadow; if issued < num_sets -> load_start=1, issued+1 -> PREFETCH; else -> LAST.
- LAST: swap_req -> done=1, buffer_ready=0 -> IDLE; weight_out retains last set.
- load_done in IDLE, READY or LAST: data discarded, err=1.
- init outside IDLE: ignored.
- Counter compares unsigned; num_sets = 2^SET_CNT_W-1 must complete without wrap.

## Timing
- All outputs registered; every response appears one cycle after the causing input edge.
- load_start, done: exactly one cycle high per event, never back-to-back from one event.
- weight_out changes only on the edge after load_done (FILL/bypass) or swap_req (READY); otherwise stable.
- init -> load_start: 1 cycle. load_done -> weight_out valid: 1 cycle. READY swap_req -> new weight_out and next load_start: same edge, 1 cycle.
- stall rises 1 cycle after unmet swap_req; falls on the edge that loads bypass data into weight_out.
- swap_req while stall already high: no additional effect.

## Test plan
- Reset mid-PREFETCH with shadow loaded -> all outputs 0 immediately (asynchronous), state IDLE; a following init (num_sets=2) restarts normally.
- num_sets=1: init, load_done weight_in=A -> weight_out=A, buffer_ready=1, no second load_start; swap_req -> done pulse, buffer_ready=0.
- num_sets=3, loader fast: sets A,B,C; B lands in shadow before swap; each swap updates weight_out in 1 cycle, stall never asserts; done after third swap; load_start count = 3.
- Slow loader: swap_req in PREFETCH 5 cycles before load_done(B) -> stall high 5 cycles, weight_out=B on edge after load_done, stall falls same edge.
- Simultaneous load_done(B) and swap_req in PREFETCH -> bypass, weight_out=B, stall never asserts, next load_start issued.
- load_done in READY -> err=1, shadow unchanged; init after run -> err=0; init with num_sets=0 -> no load_start.

Source files
------------

// File: rtl/weight_buffer_ctrl.sv
// Double-buffered weight staging: active set drives the cores while the next set
// is prefetched into a shadow register, so a swap costs one cycle.
module weight_buffer_ctrl #(
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned KERNEL_SIZE  = 9,
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned SET_CNT_W    = 8,
  localparam int unsigned BUS_W       = NUM_CORES * KERNEL_SIZE * WEIGHT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [SET_CNT_W-1:0] num_sets,
  input  logic                 load_done,
  input  logic [BUS_W-1:0]     weight_in,
  input  logic                 channel_end,
  input  logic                 core_end,
  output logic                 load_start,
  output logic [BUS_W-1:0]     weight_out,
  output logic                 buffer_ready,
  output logic                 stall,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PREFETCH,
    S_READY,
    S_LAST
  } state_e;

  state_e                state_q, state_d;
  logic [BUS_W-1:0]      weight_out_q, weight_out_d;
  logic [BUS_W-1:0]      shadow_q, shadow_d;
  logic [SET_CNT_W-1:0]  issued_q, issued_d;
  logic [SET_CNT_W-1:0]  num_sets_q, num_sets_d;
  logic                  pending_q, pending_d;
  logic                  load_start_q, load_start_d;
  logic                  buffer_ready_q, buffer_ready_d;
  logic                  stall_q, stall_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic swap_req;
  logic more_sets;

  assign swap_req  = channel_end & core_end;
  assign more_sets = (issued_q < num_sets_q);

  assign load_start   = load_start_q;
  assign weight_out   = weight_out_q;
  assign buffer_ready = buffer_ready_q;
  assign stall        = stall_q;
  assign done         = done_q;
  assign err          = err_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    weight_out_d   = weight_out_q;
    shadow_d       = shadow_q;
    issued_d       = issued_q;
    num_sets_d     = num_sets_q;
    pending_d      = pending_q;
    load_start_d   = 1'b0;
    buffer_ready_d = buffer_ready_q;
    stall_d        = stall_q;
    done_d         = 1'b0;
    err_d          = err_q;

    case (state_q)
      S_IDLE: begin
        if (load_done) err_d = 1'b1;
        // An accepted init clears err even if a stray load_done arrives with it
        if (init && (num_sets != '0)) begin
          num_sets_d   = num_sets;
          issued_d     = SET_CNT_W'(1);
          load_start_d = 1'b1;
          err_d        = 1'b0;
          pending_d    = 1'b0;
          stall_d      = 1'b0;
          state_d      = S_FILL;
        end
      end

      S_FILL: begin
        if (load_done) begin
          weight_out_d   = weight_in;
          buffer_ready_d = 1'b1;
          if (more_sets) begin
            load_start_d = 1'b1;
            issued_d     = issued_q + SET_CNT_W'(1);
            state_d      = S_PREFETCH;
          end else begin
            state_d = S_LAST;
          end
        end
      end

      S_PREFETCH: begin
        if (load_done) begin
          if (pending_q || swap_req) begin
            // Swap already owed: incoming set goes straight to the cores
            weight_out_d = weight_in;
            stall_d      = 1'b0;
            pending_d    = 1'b0;
            if (more_sets) begin
              load_start_d = 1'b1;
              issued_d     = issued_q + SET_CNT_W'(1);
            end else begin
              state_d = S_LAST;
            end
          end else begin
            shadow_d = weight_in;
            state_d  = S_READY;
          end
        end else if (swap_req) begin
          pending_d = 1'b1;
          stall_d   = 1'b1;
        end
      end

      S_READY: begin
        if (load_done) err_d = 1'b1;
        if (swap_req) begin
          weight_out_d = shadow_q;
          if (more_sets) begin
            load_start_d = 1'b1;
            issued_d     = issued_q + SET_CNT_W'(1);
            state_d      = S_PREFETCH;
          end else begin
            state_d = S_LAST;
          end
        end
      end

      S_LAST: begin
        if (load_done) err_d = 1'b1;
        if (swap_req) begin
          done_d         = 1'b1;
          buffer_ready_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      weight_out_q   <= '0;
      shadow_q       <= '0;
      issued_q       <= '0;
      num_sets_q     <= '0;
      pending_q      <= 1'b0;
      load_start_q   <= 1'b0;
      buffer_ready_q <= 1'b0;
      stall_q        <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      weight_out_q   <= weight_out_d;
      shadow_q       <= shadow_d;
      issued_q       <= issued_d;
      num_sets_q     <= num_sets_d;
      pending_q      <= pending_d;
      load_start_q   <= load_start_d;
      buffer_ready_q <= buffer_ready_d;
      stall_q        <= stall_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

endmodule
